mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- MEM-stage engine that consumes ALU_MEM pipeline-register contents (ALU result, store data, load/store control).
- Performs the data-memory transaction over a req/gnt/rvalid port.
- Hands the finished result to MEM_WB through a valid/ready handshake.
- Non-memory instructions pass through with 1-cycle latency; loads and stores stall upstream until the memory responds or a timeout expires.

Parameters:
DATA_W, 32, data and address width (fixed at 32 for RV32)
TIMEOUT, 255, max cycles from request to response before error; 8-bit counter

Ports:
clk  input  1  clock, rising edge
resetN  input  1  asynchronous, active-low reset
inValid  input  1  ALU_MEM holds a valid instruction
inReady  output  1  unit accepts the instruction this cycle
aluResult  input  32  ALU output: effective address for memory ops, result otherwise
storeData  input  32  rs2 value for stores
memRead  input  1  instruction is a load
memWrite  input  1  instruction is a store
func3  input  3  RV32 size code: 000 B, 001 H, 010 W, 100 BU, 101 HU
rdIn  input  5  destination register
regWriteIn  input  1  writes rd
memReq  output  1  data-memory request
memWe  output  1  1 = write
memAddr  output  32  word-aligned address {aluResult[31:2],2'b00}
memWdata  output  32  lane-replicated store data
memByteEn  output  4  byte enables
memGnt  input  1  request accepted
memRvalid  input  1  response / store ack
memRdata  input  32  read word
outValid  output  1  result valid to MEM_WB
outReady  input  1  MEM_WB accepts
outData  output  32  write-back value
outRd  output  5  destination register
outRegWrite  output  1  write enable to WB
outErr  output  1  misaligned access or timeout

Behaviour:
- Reset, asynchronous, any state: state=IDLE; every output 0 (memReq, memWe, memAddr, memWdata, memByteEn, outValid, outData, outRd, outRegWrite, outErr, inReady); timeout counter 0. memReq drops immediately, even mid-transaction.
- States: IDLE, REQ, WAIT, DONE.
- inReady = (state==IDLE) && !outValid, combinational. Accept = inValid && inReady; all inputs latched on accept.
- Accept of a non-memory op (memRead=memWrite=0):
  - Next cycle: outValid=1, outData=aluResult, outRd=rdIn, outRegWrite=regWriteIn, outErr=0; state DONE.
- Misaligned access: H/HU with addr[0]=1, or W with addr[1:0]!=0.
  - No memory request; next cycle outValid=1, outErr=1, outRegWrite=0, outData=aluResult; state DONE.
- Aligned memory op: next cycle enter REQ and assert memReq.
  - memAddr, memWe, memByteEn and memWdata stay stable while memReq=1.
  - REQ->WAIT on memGnt; memReq deasserts the cycle after grant.
- Memory response timing:
  - memRvalid arrives at least 1 cycle after memGnt; memRvalid while not in WAIT is ignored.
  - WAIT->DONE on memRvalid; outValid rises the following cycle.
- Byte enables:
  - B/BU: 0001<<addr[1:0].
  - H/HU: 0011<<{addr[1],1'b0}.
  - W: 1111.
  - Loads use the same enables.
- Store data: SB = byte replicated x4; SH = halfword x2; SW = as-is. Stores complete with outRegWrite=0 and outData=0.
- Load extract, from memRdata:
  - LB: lane addr[1:0], sign-extended.
  - LBU: lane addr[1:0], zero-extended.
  - LH: halfword addr[1], sign-extended.
  - LHU: halfword addr[1], zero-extended.
  - LW: full word.
- Timeout:
  - Counter clears on accept and increments every cycle in REQ or WAIT.
  - On reaching TIMEOUT with no completing handshake: memReq=0, DONE with outErr=1, outRegWrite=0.
  - A handshake in the same cycle the counter hits TIMEOUT wins; no error.
- DONE:
  - Outputs held stable while outValid && !outReady.
  - On outReady: outValid=0, state IDLE; inReady rises the next cycle. No back-to-back accept in the handoff cycle.
- Unknown func3 (011, 11x) on a memory op: treated as misaligned, outErr=1.
- Throughput: non-memory op, 1 instruction per 2 cycles with outReady=1; memory ops, at least 4 cycles.

Test Plan:
- Reset mid-WAIT (resetN low while memReq/outValid pending) -> all outputs 0 asynchronously; after release, inReady=1 and no stale outValid.
- Non-memory op, aluResult=0x1234_5678, rdIn=5, regWriteIn=1, outReady=1 -> one cycle later outValid=1, outData=0x1234_5678, outRd=5; then inReady=1.
- LB at addr 0x103, memRdata=0x80AA_BBCC, gnt 2 cycles late, rvalid 3 cycles after gnt:
  - memAddr=0x100, memByteEn=1000.
  - outData=0xFFFF_FF80, outRegWrite=1.
  - LBU, same data -> 0x0000_0080.
- SH at addr 0x202, storeData=0xDEAD_BEEF -> memWe=1, memByteEn=1100, memWdata=0xBEEF_BEEF; on rvalid, outValid=1, outRegWrite=0.
- LW at addr 0x006 -> memReq never asserted; outErr=1, outRegWrite=0.
- Memory never grants -> after 255 cycles memReq=0, outErr=1.
- Backpressure:
  - outReady low 10 cycles -> outValid/outData stable, inReady=0 throughout.
  - Late memRvalid in IDLE ignored.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// MEM-stage bundle: ALU_MEM input, data-memory port and MEM_WB output.
// slave is the unit's view; master is the surrounding pipeline/memory.
interface mem_access_unit_if;
  logic        inValid;
  logic        inReady;
  logic [31:0] aluResult;
  logic [31:0] storeData;
  logic        memRead;
  logic        memWrite;
  logic [2:0]  func3;
  logic [4:0]  rdIn;
  logic        regWriteIn;
  logic        memReq;
  logic        memWe;
  logic [31:0] memAddr;
  logic [31:0] memWdata;
  logic [3:0]  memByteEn;
  logic        memGnt;
  logic        memRvalid;
  logic [31:0] memRdata;
  logic        outValid;
  logic        outReady;
  logic [31:0] outData;
  logic [4:0]  outRd;
  logic        outRegWrite;
  logic        outErr;

  modport slave (
    input  inValid, aluResult, storeData, memRead, memWrite,
    input  func3, rdIn, regWriteIn,
    input  memGnt, memRvalid, memRdata, outReady,
    output inReady, memReq, memWe, memAddr, memWdata, memByteEn,
    output outValid, outData, outRd, outRegWrite, outErr
  );

  modport master (
    output inValid, aluResult, storeData, memRead, memWrite,
    output func3, rdIn, regWriteIn,
    output memGnt, memRvalid, memRdata, outReady,
    input  inReady, memReq, memWe, memAddr, memWdata, memByteEn,
    input  outValid, outData, outRd, outRegWrite, outErr
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage engine: runs the data-memory transaction for loads/stores
// and hands every result to MEM_WB over a valid/ready handshake.
module mem_access_unit #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input logic              clk,
  input logic              resetN,
  mem_access_unit_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    DONE
  } state_e;

  localparam logic [7:0] TO8 = 8'(TIMEOUT);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] ea_q, ea_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic              rw_q, rw_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              ovalid_q, ovalid_d;
  logic [DATA_W-1:0] odata_q, odata_d;
  logic [4:0]        ord_q, ord_d;
  logic              orw_q, orw_d;
  logic              oerr_q, oerr_d;

  logic              in_ready;
  logic              accept;
  logic              is_mem;
  logic              mis;
  logic [1:0]        a;
  logic [3:0]        be_in;
  logic [DATA_W-1:0] wd_in;
  logic [DATA_W-1:0] sh_b;
  logic [7:0]        lb;
  logic [15:0]       lh;
  logic [DATA_W-1:0] ld_val;
  logic              to_hit;

  assign in_ready = resetN & (state_q == IDLE) & ~ovalid_q;
  assign accept   = bus.inValid & in_ready;
  assign is_mem   = bus.memRead | bus.memWrite;
  assign a        = bus.aluResult[1:0];

  assign bus.inReady     = in_ready;
  assign bus.memReq      = (state_q == REQ);
  assign bus.memWe       = we_q;
  assign bus.memAddr     = {ea_q[DATA_W-1:2], 2'b00};
  assign bus.memWdata    = wdata_q;
  assign bus.memByteEn   = be_q;
  assign bus.outValid    = ovalid_q;
  assign bus.outData     = odata_q;
  assign bus.outRd       = ord_q;
  assign bus.outRegWrite = orw_q;
  assign bus.outErr      = oerr_q;

  // Size decode: lane enables, replicated store data, alignment error.
  always_comb begin
    mis   = 1'b0;
    be_in = 4'b1111;
    wd_in = bus.storeData;
    unique case (1'b1)
      bus.func3 == 3'b000, bus.func3 == 3'b100: begin
        be_in = 4'b0001 << a;
        wd_in = {4{bus.storeData[7:0]}};
      end
      bus.func3 == 3'b001, bus.func3 == 3'b101: begin
        mis   = a[0];
        be_in = 4'b0011 << {a[1], 1'b0};
        wd_in = {2{bus.storeData[15:0]}};
      end
      bus.func3 == 3'b010: mis = |a;
      default:             mis = 1'b1;
    endcase
  end

  assign sh_b = bus.memRdata >> {ea_q[1:0], 3'b000};
  assign lb   = sh_b[7:0];
  assign lh   = ea_q[1] ? bus.memRdata[31:16] : bus.memRdata[15:0];

  always_comb begin
    ld_val = bus.memRdata;
    unique case (1'b1)
      f3_q == 3'b000: ld_val = {{24{lb[7]}}, lb};
      f3_q == 3'b100: ld_val = {24'b0, lb};
      f3_q == 3'b001: ld_val = {{16{lh[15]}}, lh};
      f3_q == 3'b101: ld_val = {16'b0, lh};
      default:        ld_val = bus.memRdata;
    endcase
  end

  // Counter saturates so a late WAIT can never wrap past the limit.
  assign to_hit = (cnt_q >= TO8 - 8'd1);

  always_comb begin
    state_d  = state_q;
    ea_d     = ea_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    we_d     = we_q;
    f3_d     = f3_q;
    rw_d     = rw_q;
    cnt_d    = cnt_q;
    ovalid_d = ovalid_q;
    odata_d  = odata_q;
    ord_d    = ord_q;
    orw_d    = orw_q;
    oerr_d   = oerr_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          ea_d    = bus.aluResult;
          wdata_d = wd_in;
          be_d    = be_in;
          we_d    = bus.memWrite;
          f3_d    = bus.func3;
          rw_d    = bus.regWriteIn;
          ord_d   = bus.rdIn;
          cnt_d   = 8'd0;
          if (!is_mem) begin
            state_d  = DONE;
            ovalid_d = 1'b1;
            odata_d  = bus.aluResult;
            orw_d    = bus.regWriteIn;
            oerr_d   = 1'b0;
          end else if (mis) begin
            state_d  = DONE;
            ovalid_d = 1'b1;
            odata_d  = bus.aluResult;
            orw_d    = 1'b0;
            oerr_d   = 1'b1;
          end else begin
            state_d = REQ;
          end
        end
      end
      REQ, WAIT: begin
        if (cnt_q != TO8) cnt_d = cnt_q + 8'd1;
        if (state_q == REQ && bus.memGnt) begin
          state_d = WAIT;
        end else if (state_q == WAIT && bus.memRvalid) begin
          state_d  = DONE;
          ovalid_d = 1'b1;
          odata_d  = we_q ? '0 : ld_val;
          orw_d    = we_q ? 1'b0 : rw_q;
          oerr_d   = 1'b0;
        end else if (to_hit) begin
          state_d  = DONE;
          ovalid_d = 1'b1;
          odata_d  = ea_q;
          orw_d    = 1'b0;
          oerr_d   = 1'b1;
        end
      end
      DONE: begin
        if (bus.outReady) begin
          ovalid_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q  <= IDLE;
      ea_q     <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      we_q     <= 1'b0;
      f3_q     <= '0;
      rw_q     <= 1'b0;
      cnt_q    <= '0;
      ovalid_q <= 1'b0;
      odata_q  <= '0;
      ord_q    <= '0;
      orw_q    <= 1'b0;
      oerr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ea_q     <= ea_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      we_q     <= we_d;
      f3_q     <= f3_d;
      rw_q     <= rw_d;
      cnt_q    <= cnt_d;
      ovalid_q <= ovalid_d;
      odata_q  <= odata_d;
      ord_q    <= ord_d;
      orw_q    <= orw_d;
      oerr_q   <= oerr_d;
    end
  end
endmodule
